pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter register and instruction-fetch front end of the core; consumes the next-PC selection (`pc_next` on taken branch/jump) and produces the instruction stream for decode. Holds the fetch PC, issues in-order requests to instruction memory over a valid/ready handshake, buffers returned words in a small FIFO, and discards in-flight fetches when the PC is redirected. Also supplies `pc_plus_4` per instruction back to the next-PC mux.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `BUF_DEPTH`, 2, instruction buffer entries and maximum outstanding requests; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `redirect_valid`  in  1  non-sequential PC (taken branch, jump, jump-register) this cycle
- `redirect_pc`  in  32  target PC (next-PC mux output)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  fetch address
- `imem_resp_valid`  in  1  response word valid, in request order, never earlier than cycle after acceptance
- `imem_resp_data`  in  32  instruction word
- `if_valid`  out  1  instruction available to decode
- `if_ready`  in  1  decode accepts instruction
- `if_instr`  out  32  instruction
- `if_pc`  out  32  address of `if_instr`
- `if_pc_plus_4`  out  32  `if_pc + 4`, modulo 2^32

## Operation
- `fetch_pc` register: advances by 4 (wraps 32'hFFFF_FFFC → 0) on each request handshake; loaded with `redirect_pc` on redirect.
- Credit rule: request allowed only when `fifo_count + outstanding < BUF_DEPTH`; never overflows FIFO.
- `outstanding` increments on request handshake, decrements on each response (kept or dropped).
- Responses written to FIFO tagged with their address; FIFO head drives `if_*`.
- Redirect at cycle R: FIFO flushed at R's edge; `drop_cnt` ← outstanding responses not yet returned (excluding one arriving in R, which is discarded directly); next `drop_cnt` responses discarded; `imem_req_valid` forced 0 in R.
- Counters width `$clog2(BUF_DEPTH)+1`; `drop_cnt` ≤ `outstanding` always.
- No FSM beyond counters; fetch is always running after reset.

## Timing
- Reset (async assert): `fetch_pc`=RESET_PC, FIFO empty, counters 0, `imem_req_valid`=0, `if_valid`=0, `if_instr`/`if_pc`/`if_pc_plus_4`=0, `imem_req_addr`=RESET_PC. First request in first cycle after `rst_n` deasserts.
- Request accepted cycle N, response at N+k (k≥1) → `if_valid` at N+k+1 (registered FIFO, no bypass).
- Redirect in R → `imem_req_addr`=`redirect_pc` with `imem_req_valid` in R+1; first redirected instruction at earliest R+3.
- Redirect + `if_valid & if_ready` same cycle: handshake completes, then flush.
- Redirect + response same cycle: response discarded.
- Back-to-back redirects: latest wins; `drop_cnt` accumulates correctly.
- `if_ready`=0 with full FIFO: requests stall, `imem_req_valid` low, nothing lost.
- Reset mid-operation: all state cleared; in-flight memory responses after reset release are not expected (memory reset together).

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: adds output `fetch_misalign` (1 bit, reset 0). Redirect with `redirect_pc[1:0]`≠0 sets it, suppresses requests until next aligned redirect, which clears it.
- Undefined: no port; `redirect_pc[1:0]` ignored (treated as 0).

## Structure
- Package `fetch_pkg`: `INSTR_W`=32, `ADDR_W`=32, default `RESET_PC`, `fetch_entry_t` struct {instr, pc}.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, depth `BUF_DEPTH`, with flush input and count output.

## Test plan
- Reset release, memory ready, k=1, `if_ready`=1 → requests to 0x0,0x4,0x8…; `if_pc` sequence 0x0,0x4 with `if_pc_plus_4`=0x4,0x8.
- `if_ready`=0 for 10 cycles → exactly BUF_DEPTH requests issued, FIFO holds 0x0,0x4, no further `imem_req_valid`.
- Two requests outstanding (k=3), redirect to 0x100 → both old responses dropped; first `if_pc`=0x100.
- Redirect coincident with response and decode handshake → accepted instruction retired, response dropped, next `if_pc`=target.
- `fetch_pc`=0xFFFF_FFFC sequential → next request addr 0x0, `if_pc_plus_4`=0x0.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x102 → `fetch_misalign`=1, no requests; redirect to 0x200 → flag 0, fetch from 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // Default fetch address after reset.
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential successor of a word address; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush and occupancy count.
// Flush has priority over any write or read in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  // Qualify push/pop against occupancy so the storage can never over- or underflow.
  always_comb begin
    wr_ok_s = 1'b0;
    rd_ok_s = 1'b0;
    if (count_r != DEPTH_L) begin
      wr_ok_s = wr_en;
    end else begin
      wr_ok_s = 1'b0;
    end
    if (count_r != {CW{1'b0}}) begin
      rd_ok_s = rd_en;
    end else begin
      rd_ok_s = 1'b0;
    end
  end

  // Storage, pointers and count; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_r + CW'(wr_ok_s) - CW'(rd_ok_s);
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign empty   = (count_r == {CW{1'b0}});

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end.
// Issues in-order word fetches under a credit limit, buffers returned words
// tagged with their address, and discards in-flight fetches on redirect.
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds the fetch_misalign flag
// output and suppresses fetching after a misaligned redirect target.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus_4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              fetch_misalign
`endif
);

  localparam int                CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] resp_pc_r;
  logic              run_r;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  drop_cnt_r;

  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  fetch_entry_t      head_s;
  fetch_entry_t      wr_entry_s;
  logic [CNT_W:0]    inflight_s;
  logic              credit_ok_s;
  logic              req_valid_s;
  logic              req_fire_s;
  logic              resp_drop_s;
  logic              resp_keep_s;
  logic              deq_s;
  logic              suppress_s;
  logic [ADDR_W-1:0] redir_target_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_r;

  // Sticky misalignment flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (redirect_valid) begin
      misalign_r <= (redirect_pc[1:0] != 2'b00);
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign fetch_misalign = misalign_r;
  assign suppress_s     = misalign_r;
  assign redir_target_s = redirect_pc;
`else
  logic unused_redirect_low_s;

  assign unused_redirect_low_s = ^redirect_pc[1:0];
  assign suppress_s            = 1'b0;
  assign redir_target_s        = {redirect_pc[ADDR_W-1:2], 2'b00};
`endif

  // Request credit, handshakes and the keep/drop decision for returning words.
  always_comb begin
    inflight_s  = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
    credit_ok_s = (inflight_s < DEPTH_L);
    req_valid_s = run_r & credit_ok_s & ~redirect_valid & ~suppress_s;
    req_fire_s  = req_valid_s & imem_req_ready;
    resp_drop_s = imem_resp_valid & (redirect_valid | (drop_cnt_r != {CNT_W{1'b0}}));
    resp_keep_s = imem_resp_valid & ~resp_drop_s;
    deq_s       = ~fifo_empty_s & if_ready;
    wr_entry_s  = '{instr: imem_resp_data, pc: resp_pc_r};
  end

  // Fetch PC and the run enable that holds requests off until after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      run_r      <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (redirect_valid) begin
        fetch_pc_r <= redir_target_s;
      end else if (req_fire_s) begin
        fetch_pc_r <= pc_inc(fetch_pc_r);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

  // Address tag of the next kept response; after a redirect every older fetch is
  // dropped, so the next kept word always belongs to the redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      resp_pc_r <= redir_target_s;
    end else if (resp_keep_s) begin
      resp_pc_r <= pc_inc(resp_pc_r);
    end else begin
      resp_pc_r <= resp_pc_r;
    end
  end

  // Outstanding-request and drop counters; a redirect marks every unreturned fetch for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= {CNT_W{1'b0}};
      drop_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      outstanding_r <= outstanding_r + CNT_W'(req_fire_s) - CNT_W'(imem_resp_valid);
      if (redirect_valid) begin
        drop_cnt_r <= outstanding_r - CNT_W'(imem_resp_valid);
      end else if (resp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (resp_keep_s),
    .wr_data (wr_entry_s),
    .rd_en   (deq_s),
    .rd_data (head_s),
    .count   (fifo_count_s),
    .empty   (fifo_empty_s)
  );

  // Decode-side outputs come straight from the buffer head and read as zero when empty.
  always_comb begin
    imem_req_valid = req_valid_s;
    imem_req_addr  = fetch_pc_r;
    if_valid       = ~fifo_empty_s;
    if (!fifo_empty_s) begin
      if_instr     = head_s.instr;
      if_pc        = head_s.pc;
      if_pc_plus_4 = pc_inc(head_s.pc);
    end else begin
      if_instr     = {INSTR_W{1'b0}};
      if_pc        = {ADDR_W{1'b0}};
      if_pc_plus_4 = {ADDR_W{1'b0}};
    end
  end

endmodule
